// File: rtl/led_word_scanner.sv
// led_word_scanner: byte-serial LED display of a 32-bit register tap with a
// sticky, blinking error indicator.
//
// A coherent snapshot of value_in is taken at each frame start. One byte is
// shown at a time on led_data, with its index on led_sel. Each byte stays up
// for DWELL_CYCLES clocks. led_err blinks with a half-period of BLINK_CYCLES
// while a latched bus error is pending.
//
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous reset, active-high
//   value_in  word to display (sampled only at frame start)
//   err_in    bus-error flag (level or pulse), sets the sticky error
//   err_clr   clears the sticky error (a simultaneous err_in wins)
//   hold      freezes the scan position; error logic keeps running
//   led_data  displayed byte
//   led_sel   index of the displayed byte (0 = bits 7:0)
//   led_err   blinking sticky error indicator
module led_word_scanner #(
    parameter int unsigned DWELL_CYCLES = 50_000_000,
    parameter int unsigned BLINK_CYCLES = 25_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] value_in,
    input  logic        err_in,
    input  logic        err_clr,
    input  logic        hold,
    output logic [7:0]  led_data,
    output logic [1:0]  led_sel,
    output logic        led_err
);

    localparam int unsigned DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam int unsigned BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

    logic [DW-1:0] dwell_cnt;
    logic [1:0]    idx;
    logic [31:0]   snapshot;
    logic          load_pending;
    logic [7:0]    cur_byte;

    logic          err_sticky;
    logic [BW-1:0] blink_cnt;
    logic          blink_phase;
    logic          err_sticky_n;
    logic [BW-1:0] blink_cnt_n;
    logic          blink_phase_n;

    // Byte of the snapshot selected by the current scan index.
    always_comb begin
        cur_byte = snapshot[{idx, 3'b000} +: 8];
    end

    // Scan position, snapshot capture and registered display outputs.
    // The initial load edge acts as a frame start, so dwell_cnt stays at 0 there
    // and byte 0 of the first frame gets its full dwell time.
    always_ff @(posedge clk) begin
        if (rst) begin
            dwell_cnt    <= '0;
            idx          <= 2'd0;
            snapshot     <= 32'd0;
            load_pending <= 1'b1;
            led_data     <= 8'd0;
            led_sel      <= 2'd0;
        end else begin
            led_data <= cur_byte;
            led_sel  <= idx;
            if (load_pending) begin
                snapshot     <= value_in;
                load_pending <= 1'b0;
            end else if (!hold) begin
                if (dwell_cnt == DWELL_LAST) begin
                    dwell_cnt <= '0;
                    idx       <= idx + 2'd1;
                    if (idx == 2'd3) begin
                        snapshot <= value_in;
                    end
                end else begin
                    dwell_cnt <= dwell_cnt + DW'(1);
                end
            end
        end
    end

    // Next state of the sticky error and its blink generator.
    always_comb begin
        err_sticky_n  = (err_sticky & ~err_clr) | err_in;
        blink_cnt_n   = '0;
        blink_phase_n = 1'b0;
        if (err_sticky_n) begin
            if (!err_sticky) begin
                blink_phase_n = 1'b1;
            end else if (blink_cnt == BLINK_LAST) begin
                blink_phase_n = ~blink_phase;
            end else begin
                blink_cnt_n   = blink_cnt + BW'(1);
                blink_phase_n = blink_phase;
            end
        end
    end

    // Error registers; led_err is registered from the same next-state values.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_sticky  <= 1'b0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            led_err     <= 1'b0;
        end else begin
            err_sticky  <= err_sticky_n;
            blink_cnt   <= blink_cnt_n;
            blink_phase <= blink_phase_n;
            led_err     <= err_sticky_n & blink_phase_n;
        end
    end

endmodule

// File: tb/tb_led_word_scanner.sv
// Bench for led_word_scanner with DWELL_CYCLES=4, BLINK_CYCLES=3.
// A table of {inputs, expected outputs, repeat count} rows drives the DUT one
// cycle at a time; expected outputs go into a scoreboard queue at drive time
// and are popped and compared after the clock edge.
module tb_led_word_scanner;

    logic        clk;
    logic        rst;
    logic [31:0] value_in;
    logic        err_in;
    logic        err_clr;
    logic        hold;
    logic [7:0]  led_data;
    logic [1:0]  led_sel;
    logic        led_err;

    led_word_scanner #(
        .DWELL_CYCLES(4),
        .BLINK_CYCLES(3)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .value_in(value_in),
        .err_in  (err_in),
        .err_clr (err_clr),
        .hold    (hold),
        .led_data(led_data),
        .led_sel (led_sel),
        .led_err (led_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [31:0] value;
        logic        hold;
        logic        err_in;
        logic        err_clr;
        logic [7:0]  data;
        logic [1:0]  sel;
        logic        err;
        int          n;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic [1:0] sel;
        logic       err;
        int         row;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic add(input logic r, input logic [31:0] v, input logic h,
                       input logic ei, input logic ec, input logic [7:0] d,
                       input logic [1:0] s, input logic e, input int n);
        vec_t x;
        x.rst = r; x.value = v; x.hold = h; x.err_in = ei; x.err_clr = ec;
        x.data = d; x.sel = s; x.err = e; x.n = n;
        tbl.push_back(x);
    endtask

    task automatic check(input string name, input int row, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s row %0d: got %h want %h", name, row, act, exp);
        end
    endtask

    // One cycle: drive inputs, push expectation, clock, pop and compare.
    task automatic run_cycle(input vec_t v, input int row);
        exp_t x;
        exp_t got;
        @(negedge clk);
        rst = v.rst; value_in = v.value; hold = v.hold;
        err_in = v.err_in; err_clr = v.err_clr;
        x.data = v.data; x.sel = v.sel; x.err = v.err; x.row = row;
        sb.push_back(x);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard row %0d: got empty want entry", row);
        end else begin
            got = sb.pop_front();
            check("led_data", got.row, 32'(led_data), 32'(got.data));
            check("led_sel",  got.row, 32'(led_sel),  32'(got.sel));
            check("led_err",  got.row, 32'(led_err),  32'(got.err));
        end
    endtask

    initial begin
        rst = 1'b1; value_in = 32'd0; hold = 1'b0; err_in = 1'b0; err_clr = 1'b0;

        // rst value hold ein eclr  data sel err n
        add(1, 32'hDEADBEEF, 0, 0, 0, 8'h00, 0, 0, 2);   // 0 reset
        add(0, 32'hDEADBEEF, 0, 0, 0, 8'h00, 0, 0, 1);   // 1 initial load
        add(0, 32'hDEADBEEF, 0, 0, 0, 8'hEF, 0, 0, 4);   // 2
        add(0, 32'hDEADBEEF, 0, 0, 0, 8'hBE, 1, 0, 1);   // 3
        add(0, 32'h12345678, 0, 0, 0, 8'hBE, 1, 0, 3);   // 4 value change mid-frame
        add(0, 32'h12345678, 0, 0, 0, 8'hAD, 2, 0, 4);   // 5
        add(0, 32'h12345678, 0, 0, 0, 8'hDE, 3, 0, 4);   // 6 reload on last edge
        add(0, 32'h12345678, 0, 0, 0, 8'h78, 0, 0, 4);   // 7
        add(0, 32'h12345678, 0, 0, 0, 8'h56, 1, 0, 4);   // 8
        add(0, 32'h12345678, 0, 0, 0, 8'h34, 2, 0, 4);   // 9
        add(0, 32'hDEADBEEF, 0, 0, 0, 8'h12, 3, 0, 4);   // 10
        add(0, 32'hDEADBEEF, 0, 0, 0, 8'hEF, 0, 0, 4);   // 11
        add(0, 32'hDEADBEEF, 0, 0, 0, 8'hBE, 1, 0, 4);   // 12
        add(0, 32'hDEADBEEF, 0, 0, 0, 8'hAD, 2, 0, 2);   // 13
        add(0, 32'hDEADBEEF, 1, 0, 0, 8'hAD, 2, 0, 10);  // 14 hold
        add(0, 32'hDEADBEEF, 0, 0, 0, 8'hAD, 2, 0, 2);   // 15 resume
        add(0, 32'hDEADBEEF, 0, 0, 0, 8'hDE, 3, 0, 4);   // 16
        add(0, 32'hDEADBEEF, 0, 0, 0, 8'hEF, 0, 0, 1);   // 17
        add(0, 32'hDEADBEEF, 1, 1, 0, 8'hEF, 0, 1, 1);   // 18 err pulse
        add(0, 32'hDEADBEEF, 1, 0, 0, 8'hEF, 0, 1, 2);   // 19
        add(0, 32'hDEADBEEF, 1, 0, 0, 8'hEF, 0, 0, 3);   // 20
        add(0, 32'hDEADBEEF, 1, 0, 0, 8'hEF, 0, 1, 3);   // 21
        add(0, 32'hDEADBEEF, 1, 0, 0, 8'hEF, 0, 0, 3);   // 22
        add(0, 32'hDEADBEEF, 1, 0, 1, 8'hEF, 0, 0, 1);   // 23 clear
        add(0, 32'hDEADBEEF, 1, 0, 0, 8'hEF, 0, 0, 3);   // 24
        add(0, 32'hDEADBEEF, 1, 1, 1, 8'hEF, 0, 1, 1);   // 25 set+clr from idle
        add(0, 32'hDEADBEEF, 1, 1, 1, 8'hEF, 0, 1, 1);   // 26 set+clr while set
        add(0, 32'hDEADBEEF, 1, 0, 0, 8'hEF, 0, 1, 1);   // 27
        add(0, 32'hDEADBEEF, 1, 0, 0, 8'hEF, 0, 0, 3);   // 28
        add(0, 32'hDEADBEEF, 1, 0, 1, 8'hEF, 0, 0, 1);   // 29 clear
        add(0, 32'hDEADBEEF, 0, 0, 0, 8'hEF, 0, 0, 3);   // 30
        add(0, 32'hDEADBEEF, 0, 0, 0, 8'hBE, 1, 0, 4);   // 31
        add(0, 32'hDEADBEEF, 0, 0, 0, 8'hAD, 2, 0, 4);   // 32
        add(0, 32'hDEADBEEF, 0, 1, 0, 8'hDE, 3, 1, 1);   // 33 err while sel=3
        add(0, 32'hDEADBEEF, 0, 0, 0, 8'hDE, 3, 1, 1);   // 34
        add(1, 32'hCAFEF00D, 1, 1, 1, 8'h00, 0, 0, 2);   // 35 reset mid-operation
        add(0, 32'hCAFEF00D, 0, 0, 0, 8'h00, 0, 0, 1);   // 36 load
        add(0, 32'hCAFEF00D, 0, 0, 0, 8'h0D, 0, 0, 4);   // 37
        add(0, 32'hCAFEF00D, 0, 0, 0, 8'hF0, 1, 0, 4);   // 38
        add(0, 32'hCAFEF00D, 0, 0, 0, 8'hFE, 2, 0, 4);   // 39
        add(0, 32'hCAFEF00D, 0, 0, 0, 8'hCA, 3, 0, 4);   // 40
        add(0, 32'hCAFEF00D, 0, 0, 0, 8'h0D, 0, 0, 2);   // 41
        add(1, 32'h89ABCDEF, 0, 0, 0, 8'h00, 0, 0, 1);   // 42 reset
        add(0, 32'h89ABCDEF, 1, 0, 0, 8'h00, 0, 0, 1);   // 43 load despite hold
        add(0, 32'h89ABCDEF, 1, 0, 0, 8'hEF, 0, 0, 3);   // 44
        add(0, 32'h89ABCDEF, 0, 0, 0, 8'hEF, 0, 0, 4);   // 45
        add(0, 32'h89ABCDEF, 0, 0, 0, 8'hCD, 1, 0, 1);   // 46

        foreach (tbl[r]) begin
            for (int c = 0; c < tbl[r].n; c++) begin
                run_cycle(tbl[r], r);
            end
        end

        // led_err must not follow err_in combinationally; it changes at the edge.
        @(negedge clk);
        err_in = 1'b1;
        #2;
        check("err_comb_path", 100, 32'(led_err), 32'd0);
        @(posedge clk);
        #1;
        check("err_set_edge", 101, 32'(led_err), 32'd1);
        @(negedge clk);
        err_in = 1'b0;
        err_clr = 1'b1;
        #2;
        check("err_clr_comb_path", 102, 32'(led_err), 32'd1);
        @(posedge clk);
        #1;
        check("err_clr_edge", 103, 32'(led_err), 32'd0);
        @(negedge clk);
        err_clr = 1'b0;

        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain row 0: got %0d want 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/led_word_scanner.md
Name: led_word_scanner

Overview:
- Display stage that consumes the CPU's 32-bit register tap (r1) and the bus-error flag, and drives the board LEDs.
- Replaces lossy per-nibble OR-reduction with a byte-serial scan: captures a coherent snapshot of the word, shows one byte at a time on 8 LEDs with a 2-bit byte index, and presents a sticky, blinking error indicator.
- Sits between riscv_top_wrapper and the top-level LED pins.

Parameters:
- DWELL_CYCLES, 50_000_000: clocks each byte is displayed; must be >= 2.
- BLINK_CYCLES, 25_000_000: clocks per half-period of the error blink; must be >= 1.

Ports:
- clk       input   1   system clock; all logic on rising edge
- rst       input   1   synchronous reset, active-high
- value_in  input   32  word to display (CPU r1 tap)
- err_in    input   1   bus-error flag from CPU, level or pulse
- err_clr   input   1   clears the sticky error
- hold      input   1   freezes the scan on the current byte
- led_data  output  8   displayed byte
- led_sel   output  2   binary index of the displayed byte (0 = bits 7:0)
- led_err   output  1   blinking sticky error indicator

Behaviour:
- Reset (rst=1 at an edge) clears all state:
  - dwell_cnt=0, idx=0, snapshot=0.
  - led_data=0, led_sel=0.
  - err_sticky=0, blink_cnt=0, blink_phase=0, so led_err=0.
  - Sets load_pending=1.
- Snapshot load:
  - On the first edge with rst=0 after reset: snapshot<=value_in, load_pending<=0.
  - Afterwards, snapshot reloads only on the edge where idx wraps 3->0.
  - value_in is ignored at all other times, so a displayed frame is always one coherent word.
- Scan, when hold=0:
  - dwell_cnt counts 0..DWELL_CYCLES-1.
  - On the edge where dwell_cnt==DWELL_CYCLES-1: dwell_cnt<=0, idx<=idx+1 (mod 4).
  - If idx==3 on that edge, the snapshot reloads on the same edge.
- Scan, when hold=1:
  - dwell_cnt, idx and snapshot hold their values.
  - Scanning resumes from the frozen count when hold drops.
  - hold has no effect on the error logic.
  - A hold asserted on the load_pending edge does not block the initial load.
- Outputs:
  - led_data and led_sel are registered: each edge, led_data<=snapshot[8*idx+7 -: 8] and led_sel<=idx, using pre-edge register values.
  - Latency: value_in sampled at frame-start edge E appears as byte 0 on led_data after edge E+1.
  - Each byte is shown for exactly DWELL_CYCLES cycles when hold=0.
- Error:
  - err_sticky<=(err_sticky & ~err_clr) | err_in; set wins over a simultaneous clear.
  - On the edge err_sticky goes 0->1: blink_cnt<=0, blink_phase<=1.
  - While err_sticky=1: blink_cnt counts 0..BLINK_CYCLES-1; at terminal count it wraps to 0 and blink_phase toggles.
  - While err_sticky=0: blink_cnt=0, blink_phase=0.
  - led_err = err_sticky & blink_phase, driven only from registers (no input-to-output combinational path).
- Reset mid-operation: state is cleared at that edge regardless of hold, err_in or err_clr. The sequence restarts with a fresh snapshot load after release.

Test Plan (DWELL_CYCLES=4, BLINK_CYCLES=3):
1. Release rst with value_in=32'hDEADBEEF constant -> led_data/led_sel = EF/0, BE/1, AD/2, DE/3, each for 4 cycles starting after edge 1, then repeat.
2. Switch value_in to 32'h12345678 while led_sel=1 -> remaining bytes of the frame stay AD, DE; next frame shows 78, 56, 34, 12.
3. Assert hold for 10 cycles during the second cycle of idx=2 -> led_data=AD, led_sel=2 throughout; after release, AD is shown for 2 more cycles, then DE.
4. One-cycle err_in pulse -> led_err 1 for 3 cycles, 0 for 3 cycles, repeating. err_clr pulse -> led_err=0 from the next edge. err_in and err_clr together -> error stays set.
5. Assert rst while led_sel=3 with the error blinking -> led_data=0, led_sel=0, led_err=0 after that edge. After release, the new value_in is snapshotted on the first edge and its byte 0 is shown after the second.
